// File: rtl/mash_cfg_sequencer.sv
// Sequences config words into the MASH DDSM core: hold in reset, optional phase adjust, settle, run.
// Define MASH_PHASE_ADJ_EN to include the PHASE state; otherwise RESET goes straight to SETTLE.
//
// state  | meaning
// IDLE   | MASH held in reset, waiting for a valid config
// RESET  | MASH reset asserted for RST_CYCLES
// PHASE  | phase-adjust pulse for PA_CYCLES (MASH_PHASE_ADJ_EN only)
// SETTLE | controls released, waiting SETTLE_CYCLES
// RUN    | MASH running on the applied config, locked
module mash_cfg_sequencer #(
    parameter int RST_CYCLES    = 4,
    parameter int PA_CYCLES     = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic [11:0] i_seed,
    input  logic [1:0]  i_sel_order,
    input  logic [3:0]  i_mash_bit,
    input  logic        i_sel_frac,
    input  logic        i_abort,
    output logic [11:0] o_seed,
    output logic [1:0]  o_sel_order,
    output logic [3:0]  o_mash_bit,
    output logic        o_sel_frac,
    output logic        o_mashreseten,
    output logic        o_phaseadjusten,
    output logic        o_locked,
    output logic        o_cfg_err
);

`ifdef MASH_PHASE_ADJ_EN
    typedef enum logic [2:0] {ST_IDLE, ST_RESET, ST_PHASE, ST_SETTLE, ST_RUN} state_t;
    localparam logic [CNT_W-1:0] PA_TC = CNT_W'(PA_CYCLES - 1);
`else
    typedef enum logic [2:0] {ST_IDLE, ST_RESET, ST_SETTLE, ST_RUN} state_t;
    logic [CNT_W-1:0] unused_pa_tc;
    assign unused_pa_tc = CNT_W'(PA_CYCLES - 1);
`endif

    localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      seed_q, seed_d;
    logic [1:0]       order_q, order_d;
    logic [3:0]       mash_bit_q, mash_bit_d;
    logic             frac_q, frac_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             mrst_q, mrst_d;
    logic             pa_q, pa_d;
    logic             locked_q, locked_d;

    logic             accept;
    logic             cfg_bad;

    always_comb begin
        accept     = i_cfg_valid && ready_q && !i_abort;
        cfg_bad    = (i_mash_bit == 4'd0) || (i_sel_order == 2'd0);

        state_d    = state_q;
        cnt_d      = cnt_q;
        seed_d     = seed_q;
        order_d    = order_q;
        mash_bit_d = mash_bit_q;
        frac_d     = frac_q;
        err_d      = 1'b0;

        // Abort outranks everything; a rejected config leaves the sequence untouched.
        if (i_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept && cfg_bad) begin
            err_d = 1'b1;
        end else if (accept) begin
            seed_d     = i_seed;
            order_d    = i_sel_order;
            mash_bit_d = i_mash_bit;
            frac_d     = i_sel_frac;
            state_d    = ST_RESET;
            cnt_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RESET: begin
                    if (cnt_q >= RST_TC) begin
`ifdef MASH_PHASE_ADJ_EN
                        state_d = ST_PHASE;
`else
                        state_d = ST_SETTLE;
`endif
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`ifdef MASH_PHASE_ADJ_EN
                ST_PHASE: begin
                    if (cnt_q >= PA_TC) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`endif
                ST_SETTLE: begin
                    if (cnt_q >= SETTLE_TC) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: ;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they line up with the state register.
        ready_d  = ((state_d == ST_IDLE) || (state_d == ST_RUN)) && !i_abort;
        mrst_d   = (state_d == ST_IDLE) || (state_d == ST_RESET);
`ifdef MASH_PHASE_ADJ_EN
        pa_d     = (state_d == ST_PHASE);
`else
        pa_d     = 1'b0;
`endif
        locked_d = (state_d == ST_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seed_q     <= '0;
            order_q    <= '0;
            mash_bit_q <= '0;
            frac_q     <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            mrst_q     <= 1'b1;
            pa_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seed_q     <= seed_d;
            order_q    <= order_d;
            mash_bit_q <= mash_bit_d;
            frac_q     <= frac_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            mrst_q     <= mrst_d;
            pa_q       <= pa_d;
            locked_q   <= locked_d;
        end
    end

    assign o_cfg_ready     = ready_q;
    assign o_cfg_err       = err_q;
    assign o_seed          = seed_q;
    assign o_sel_order     = order_q;
    assign o_mash_bit      = mash_bit_q;
    assign o_sel_frac      = frac_q;
    assign o_mashreseten   = mrst_q;
    assign o_phaseadjusten = pa_q;
    assign o_locked        = locked_q;

endmodule

// File: tb/tb_mash_cfg_sequencer.sv
// Bench for mash_cfg_sequencer: timer-based reference model checked every cycle, directed scenarios, random traffic.
`timescale 1ns/1ps
module tb_mash_cfg_sequencer;

    localparam int RST_C = 4;
    localparam int PA_C  = 2;
    localparam int SET_C = 8;
`ifdef MASH_PHASE_ADJ_EN
    localparam int PA_EFF  = PA_C;
    localparam int EXP_LAT = 15;
`else
    localparam int PA_EFF  = 0;
    localparam int EXP_LAT = 13;
`endif
    localparam int LOCK_T = RST_C + PA_EFF + SET_C;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [11:0] i_seed;
    logic [1:0]  i_sel_order;
    logic [3:0]  i_mash_bit;
    logic        i_sel_frac;
    logic        i_abort;
    logic [11:0] o_seed;
    logic [1:0]  o_sel_order;
    logic [3:0]  o_mash_bit;
    logic        o_sel_frac;
    logic        o_mashreseten;
    logic        o_phaseadjusten;
    logic        o_locked;
    logic        o_cfg_err;

    mash_cfg_sequencer #(
        .RST_CYCLES(RST_C), .PA_CYCLES(PA_C), .SETTLE_CYCLES(SET_C), .CNT_W(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_seed(i_seed), .i_sel_order(i_sel_order), .i_mash_bit(i_mash_bit), .i_sel_frac(i_sel_frac),
        .i_abort(i_abort), .o_seed(o_seed), .o_sel_order(o_sel_order), .o_mash_bit(o_mash_bit),
        .o_sel_frac(o_sel_frac), .o_mashreseten(o_mashreseten), .o_phaseadjusten(o_phaseadjusten),
        .o_locked(o_locked), .o_cfg_err(o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts edges since the last valid accept.
    bit          model_ok = 1'b0;
    bit          m_idle;
    int          m_t;
    bit          m_ready;
    bit          m_err;
    bit          m_acc;
    logic [11:0] m_seed;
    logic [1:0]  m_order;
    logic [3:0]  m_bit;
    logic        m_frac;

    always @(posedge i_clk) begin
        if (i_rst) begin
            model_ok = 1'b1;
            m_idle = 1'b1; m_t = 0; m_ready = 1'b1; m_err = 1'b0;
            m_seed = '0; m_order = '0; m_bit = '0; m_frac = 1'b0;
        end else if (model_ok) begin
            m_acc = i_cfg_valid && m_ready && !i_abort;
            m_err = 1'b0;
            if (i_abort) begin
                m_idle = 1'b1;
            end else if (m_acc && (i_mash_bit == 4'd0 || i_sel_order == 2'd0)) begin
                m_err = 1'b1;
            end else if (m_acc) begin
                m_idle = 1'b0; m_t = 0;
                m_seed = i_seed; m_order = i_sel_order; m_bit = i_mash_bit; m_frac = i_sel_frac;
            end else if (!m_idle && m_t < 1000) begin
                m_t++;
            end
            m_ready = !i_abort && (m_idle || m_t >= LOCK_T);
        end
    end

    always @(negedge i_clk) begin
        if (model_ok) begin
            chk("cfg_ready", o_cfg_ready, m_ready);
            chk("cfg_err", o_cfg_err, m_err);
            chk("mashreseten", o_mashreseten, m_idle || m_t < RST_C);
            chk("phaseadjusten", o_phaseadjusten,
                !m_idle && m_t >= RST_C && m_t < RST_C + PA_EFF);
            chk("locked", o_locked, !m_idle && m_t >= LOCK_T);
            chk("seed", o_seed, m_seed);
            chk("sel_order", o_sel_order, m_order);
            chk("mash_bit", o_mash_bit, m_bit);
            chk("sel_frac", o_sel_frac, m_frac);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_cfg_ready && n < 100) begin
            tick();
            n++;
        end
        if (!o_cfg_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic offer(input logic [11:0] s, input logic [1:0] o, input logic [3:0] b, input logic f);
        wait_ready();
        i_seed = s; i_sel_order = o; i_mash_bit = b; i_sel_frac = f;
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    // Returns cycles from the accept cycle to the first locked cycle (accept cycle counted as 1).
    task automatic lock_latency(output int lat);
        int n = 0;
        while (!o_locked && n < 60) begin
            tick();
            n++;
        end
        lat = n + 1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mashreseten"}, o_mashreseten, 1);
        chk({tag, "_phaseadjusten"}, o_phaseadjusten, 0);
        chk({tag, "_locked"}, o_locked, 0);
        chk({tag, "_ready"}, o_cfg_ready, 1);
        chk({tag, "_err"}, o_cfg_err, 0);
        chk({tag, "_seed"}, o_seed, 0);
        chk({tag, "_cfg"}, {o_sel_order, o_mash_bit, o_sel_frac}, 0);
    endtask

    initial begin
        int lat;
        int n;
        int seen_ready;
        i_rst = 1'b1; i_cfg_valid = 1'b0; i_abort = 1'b0;
        i_seed = '0; i_sel_order = '0; i_mash_bit = '0; i_sel_frac = 1'b0;
        repeat (3) tick();
        chk_reset_vals("reset");
        i_rst = 1'b0;
        tick();

        // Nominal config and its latency.
        offer(12'hA5C, 2'd3, 4'd8, 1'b1);
        chk("t1_mashreseten_after_accept", o_mashreseten, 1);
        lock_latency(lat);
        chk("t1_latency", lat, EXP_LAT);
        chk("t1_seed", o_seed, 12'hA5C);
        chk("t1_order", o_sel_order, 2'd3);
        chk("t1_bit", o_mash_bit, 4'd8);
        chk("t1_frac", o_sel_frac, 1'b1);

        // Invalid width offered while running.
        tick();
        i_seed = 12'h123; i_sel_order = 2'd1; i_mash_bit = 4'd0; i_sel_frac = 1'b0;
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
        chk("t2_err_pulse", o_cfg_err, 1);
        chk("t2_locked_kept", o_locked, 1);
        chk("t2_seed_kept", o_seed, 12'hA5C);
        tick();
        chk("t2_err_single", o_cfg_err, 0);

        // Abort two cycles into SETTLE.
        offer(12'h3C1, 2'd2, 4'd5, 1'b0);
        n = 0;
        while ((o_mashreseten || o_phaseadjusten) && n < 40) begin
            tick();
            n++;
        end
        tick(); tick();
        i_abort = 1'b1;
        tick();
        chk("t3_mashreseten", o_mashreseten, 1);
        chk("t3_locked", o_locked, 0);
        chk("t3_seed_kept", o_seed, 12'h3C1);
        chk("t3_ready_low", o_cfg_ready, 0);
        i_abort = 1'b0;
        tick();
        chk("t3_ready_back", o_cfg_ready, 1);

        // Valid held through the whole sequence.
        i_seed = 12'h7E2; i_sel_order = 2'd1; i_mash_bit = 4'd12; i_sel_frac = 1'b1;
        i_cfg_valid = 1'b1;
        tick();
        n = 0;
        seen_ready = 0;
        while (!o_locked && n < 60) begin
            if (o_cfg_ready) seen_ready++;
            tick();
            n++;
        end
        chk("t4_ready_busy", seen_ready, 0);
        chk("t4_latency", n + 1, EXP_LAT);
        tick();
        chk("t4_restart_locked", o_locked, 0);
        chk("t4_restart_mashreseten", o_mashreseten, 1);
        i_cfg_valid = 1'b0;

        // Synchronous reset in the middle of the sequence.
        offer(12'h0F0, 2'd1, 4'd15, 1'b0);
        n = 0;
        while (((PA_EFF > 0) ? !o_phaseadjusten : o_mashreseten) && n < 40) begin
            tick();
            n++;
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_reset_vals("t5");
        offer(12'hA5C, 2'd3, 4'd8, 1'b1);
        lock_latency(lat);
        chk("t5_latency", lat, EXP_LAT);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            i_rst       = ($urandom_range(0, 299) == 0);
            i_abort     = ($urandom_range(0, 59) == 0);
            i_cfg_valid = ($urandom_range(0, 23) == 0);
            i_seed      = 12'($urandom);
            i_sel_order = 2'($urandom_range(0, 3));
            i_mash_bit  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            i_sel_frac  = 1'($urandom);
            tick();
        end
        i_rst = 1'b0; i_abort = 1'b0; i_cfg_valid = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
